// File: rtl/line_feeder.sv
// -----------------------------------------------------------------------------
// line_feeder
//
// Input sequencer and result collector for the three-stage assembly line
// (bloc/registru chain with inputs x, t, y and output z).
//
// Operand triples arrive over a valid/ready handshake and are queued in a small
// circular FIFO. When run is high, the head item is issued. Its x/t drive the
// line directly. Its y is held back one cycle so that it meets that item's
// stage-1 register. A 3-deep valid tracker follows each issued item down the
// line and marks the cycle in which its z appears at the line output.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   CNT_W : width of the delivered-result counter
//
// Ports
//   clk, reset         : clock; synchronous active-high reset
//   in_valid/in_ready  : upstream handshake (in_ready = !full)
//   in_x, in_t, in_y   : operand triple
//   run                : issue enable
//   line_x, line_t     : registered x/t into the line
//   line_y             : registered y into the line, one cycle behind x/t
//   line_z             : z from the line
//   res_valid, res_z   : result strobe and value (res_z = line_z)
//   res_count          : results delivered, modulo 2^CNT_W
//   busy               : FIFO non-empty or any item still in the line
// -----------------------------------------------------------------------------
module line_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_x,
  input  logic             in_t,
  input  logic             in_y,
  input  logic             run,
  output logic             line_x,
  output logic             line_t,
  output logic             line_y,
  input  logic             line_z,
  output logic             res_valid,
  output logic             res_z,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] RES_ONE  = CNT_W'(1);

  typedef struct packed {
    logic x;
    logic t;
    logic y;
  } item_t;

  // FIFO storage and control
  item_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  // Issue stage and skew register
  logic r_line_x_p0;
  logic r_line_t_p0;
  logic r_y_hold_p0;
  logic r_iss_vld_p0;

  // Line-side y and valid tracker
  logic r_line_y_p1;
  logic r_vld_p1;
  logic r_vld_p2;
  logic r_vld_p3;

  logic [CNT_W-1:0] r_res_count;

  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_pop;
  item_t w_head;

  // in_ready depends only on the registered count. So a pop on the same edge
  // never lets a push into a full FIFO.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = run && !w_empty;
  assign w_head  = r_mem[r_rptr];

  // ---- FIFO write (storage is data only, never reset) ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{x: in_x, t: in_t, y: in_y};
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two. The count
  // carries one extra bit so that full and empty stay distinct.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- p0: issue head item, or insert a bubble ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_x_p0  <= 1'b0;
      r_line_t_p0  <= 1'b0;
      r_y_hold_p0  <= 1'b0;
      r_iss_vld_p0 <= 1'b0;
    end else if (w_pop) begin
      r_line_x_p0  <= w_head.x;
      r_line_t_p0  <= w_head.t;
      r_y_hold_p0  <= w_head.y;
      r_iss_vld_p0 <= 1'b1;
    end else begin
      r_line_x_p0  <= 1'b0;
      r_line_t_p0  <= 1'b0;
      r_y_hold_p0  <= 1'b0;
      r_iss_vld_p0 <= 1'b0;
    end
  end

  // ---- p1..p3: y skew into the line, valid follows the item through the line ----
  // The tracker keeps shifting when run is low. A pause therefore only stops
  // new issues and never stalls items already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_y_p1 <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_vld_p3    <= 1'b0;
    end else begin
      r_line_y_p1 <= r_y_hold_p0;
      r_vld_p1    <= r_iss_vld_p0;
      r_vld_p2    <= r_vld_p1;
      r_vld_p3    <= r_vld_p2;
    end
  end

  // ---- result counter: counts each cycle in which a result is presented ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_count <= '0;
    end else if (r_vld_p3) begin
      r_res_count <= r_res_count + RES_ONE;
    end
  end

  assign in_ready  = !w_full;
  assign line_x    = r_line_x_p0;
  assign line_t    = r_line_t_p0;
  assign line_y    = r_line_y_p1;
  assign res_valid = r_vld_p3;
  assign res_z     = line_z;
  assign res_count = r_res_count;
  assign busy      = !w_empty | r_iss_vld_p0 | r_vld_p1 | r_vld_p2 | r_vld_p3;

endmodule

// File: tb/tb_line_feeder.sv
module tb_line_feeder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, in_x, in_t, in_y, run;

  // Instance A: CNT_W = 8
  logic       a_in_ready, a_line_x, a_line_t, a_line_y, a_line_z;
  logic       a_res_valid, a_res_z, a_busy;
  logic [7:0] a_res_count;

  // Instance B: CNT_W = 2 (counter wrap)
  logic       b_in_ready, b_line_x, b_line_t, b_line_y, b_line_z;
  logic       b_res_valid, b_res_z, b_busy;
  logic [1:0] b_res_count;

  line_feeder #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_x(in_x), .in_t(in_t), .in_y(in_y), .run(run),
    .line_x(a_line_x), .line_t(a_line_t), .line_y(a_line_y), .line_z(a_line_z),
    .res_valid(a_res_valid), .res_z(a_res_z), .res_count(a_res_count), .busy(a_busy)
  );

  line_feeder #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_x(in_x), .in_t(in_t), .in_y(in_y), .run(run),
    .line_x(b_line_x), .line_t(b_line_t), .line_y(b_line_y), .line_z(b_line_z),
    .res_valid(b_res_valid), .res_z(b_res_z), .res_count(b_res_count), .busy(b_busy)
  );

  // Line stubs: z = x delayed by 3 cycles, same reset as the feeder.
  logic [2:0] a_sh, b_sh;
  always @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
    end else begin
      a_sh <= {a_sh[1:0], a_line_x};
      b_sh <= {b_sh[1:0], b_line_x};
    end
  end
  assign a_line_z = a_sh[2];
  assign b_line_z = b_sh[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic x; logic t; logic y; } item_t;
  typedef struct packed { int due; logic x; } res_t;

  item_t mq[$];
  res_t  rq[$];
  int    edge_n = 0;
  logic  m_line_x = 0, m_line_t = 0, m_line_y = 0, m_ypend = 0;
  logic  m_res_valid = 0, m_res_z = 0, m_busy = 0, m_ready = 1;
  int    m_cnt = 0;

  // Logs of what the DUT delivered, for the directed literal checks.
  logic  got_z[$];
  int    got_edge[$];
  int    cnt2_log[$];
  logic  prev_b_rv = 0;

  task automatic model_step();
    item_t it;
    logic  pop, pushok;
    edge_n++;
    if (reset) begin
      mq.delete();
      rq.delete();
      m_line_x = 0; m_line_t = 0; m_line_y = 0; m_ypend = 0;
      m_res_valid = 0; m_res_z = 0; m_cnt = 0;
    end else begin
      if (m_res_valid) m_cnt++;
      m_line_y = m_ypend;
      pop    = run && (mq.size() > 0);
      pushok = in_valid && (mq.size() < DEPTH);
      if (pop) begin
        it = mq.pop_front();
        m_line_x = it.x; m_line_t = it.t; m_ypend = it.y;
        rq.push_back('{due: edge_n + 3, x: it.x});
      end else begin
        m_line_x = 0; m_line_t = 0; m_ypend = 0;
      end
      if (pushok) mq.push_back('{x: in_x, t: in_t, y: in_y});
      while (rq.size() > 0 && rq[0].due < edge_n) void'(rq.pop_front());
      m_res_valid = (rq.size() > 0) && (rq[0].due == edge_n);
      m_res_z     = m_res_valid ? rq[0].x : 1'b0;
    end
    m_busy  = (mq.size() != 0) || (rq.size() != 0);
    m_ready = (mq.size() < DEPTH);
  endtask

  // Model update at each edge, full comparison 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("in_ready",  a_in_ready,  m_ready);
      chk("line_x",    a_line_x,    m_line_x);
      chk("line_t",    a_line_t,    m_line_t);
      chk("line_y",    a_line_y,    m_line_y);
      chk("res_valid", a_res_valid, m_res_valid);
      if (m_res_valid) chk("res_z", a_res_z, m_res_z);
      chk("res_count", a_res_count, m_cnt % 256);
      chk("busy",      a_busy,      m_busy);
      chk("b_res_valid", b_res_valid, m_res_valid);
      chk("b_res_count", b_res_count, m_cnt % 4);
      if (a_res_valid) begin
        got_z.push_back(a_res_z);
        got_edge.push_back(edge_n);
      end
      if (prev_b_rv) cnt2_log.push_back(int'(b_res_count));
      prev_b_rv = b_res_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rs, input logic v, input logic x, input logic t,
                      input logic y, input logic r);
    @(negedge clk);
    reset = rs; in_valid = v; in_x = x; in_t = t; in_y = y; run = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, r);
  endtask

  task automatic clear_logs();
    got_z.delete();
    got_edge.delete();
    cnt2_log.delete();
  endtask

  task automatic chk_z(input string nm, input logic exp_z[$]);
    chk({nm, "_n"}, got_z.size(), exp_z.size());
    for (int i = 0; i < exp_z.size(); i++)
      chk($sformatf("%s_z%0d", nm, i), (i < got_z.size()) ? 32'(got_z[i]) : 'x, exp_z[i]);
  endtask

  logic [7:0] base;

  initial begin
    reset = 1; in_valid = 0; in_x = 0; in_t = 0; in_y = 0; run = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_in_ready",  a_in_ready,  1);
    chk("rst_line_x",    a_line_x,    0);
    chk("rst_line_y",    a_line_y,    0);
    chk("rst_res_valid", a_res_valid, 0);
    chk("rst_res_count", a_res_count, 0);
    chk("rst_busy",      a_busy,      0);

    // Single item (x=1,t=0,y=1)
    clear_logs();
    step(0, 1, 1, 0, 1, 1);                       // e0 push
    step(0, 0, 0, 0, 0, 1);                       // e1 issue
    chk("t1_line_x", a_line_x, 1);
    chk("t1_line_t", a_line_t, 0);
    step(0, 0, 0, 0, 0, 1);                       // e2
    chk("t1_line_y", a_line_y, 1);
    step(0, 0, 0, 0, 0, 1);                       // e3
    chk("t1_early_valid", a_res_valid, 0);
    step(0, 0, 0, 0, 0, 1);                       // e4
    chk("t1_res_valid", a_res_valid, 1);
    chk("t1_res_z",     a_res_z,     1);
    step(0, 0, 0, 0, 0, 1);                       // e5
    chk("t1_res_count", a_res_count, 1);
    chk("t1_busy",      a_busy,      0);

    // Burst x = 1,0,1,1
    clear_logs();
    base = a_res_count;
    step(0, 1, 1, 0, 1, 1);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 1, 0, 1, 1);
    step(0, 1, 1, 0, 0, 1);
    idle(8, 1);
    chk_z("t2", '{1'b1, 1'b0, 1'b1, 1'b1});
    chk("t2_contig", (got_edge.size() == 4) ? 32'(got_edge[3] - got_edge[0]) : 'x, 3);
    chk("t2_count_delta", 32'(8'(a_res_count - base)), 4);
    chk("t2_res_count", a_res_count, 5);

    // Full FIFO: run low, offer 6 cycles, then release
    clear_logs();
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk("t3_full_ready", a_in_ready, 0);
    step(0, 1, 1, 0, 1, 0);                       // 5th offer refused
    step(0, 1, 1, 0, 1, 0);                       // still refused
    chk("t3_still_full", a_in_ready, 0);
    step(0, 1, 1, 0, 1, 1);                       // first pop, push refused
    chk("t3_ready_back", a_in_ready, 1);
    step(0, 1, 1, 0, 1, 1);                       // 5th accepted
    idle(10, 1);
    chk_z("t3", '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

    // Run gap with 3 items queued
    clear_logs();
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(8, 1);
    chk_z("t4", '{1'b1, 1'b1, 1'b0});
    chk("t4_gap",  (got_edge.size() == 3) ? 32'(got_edge[1] - got_edge[0]) : 'x, 2);
    chk("t4_next", (got_edge.size() == 3) ? 32'(got_edge[2] - got_edge[1]) : 'x, 1);

    // Reset mid-flight
    clear_logs();
    step(0, 1, 1, 0, 1, 1);                       // push item 1
    step(0, 1, 1, 1, 1, 1);                       // issue 1, push 2
    step(0, 0, 0, 0, 0, 1);                       // issue 2
    step(1, 0, 0, 0, 0, 1);                       // reset edge
    chk("t5_line_x",    a_line_x,    0);
    chk("t5_line_t",    a_line_t,    0);
    chk("t5_line_y",    a_line_y,    0);
    chk("t5_res_count", a_res_count, 0);
    chk("t5_in_ready",  a_in_ready,  1);
    chk("t5_busy",      a_busy,      0);
    idle(6, 1);
    chk("t5_no_results", got_z.size(), 0);
    chk("t5_count_after", a_res_count, 0);

    // Counter wrap on the CNT_W=2 instance
    clear_logs();
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 1, 1, 0, 1);
    step(0, 1, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1, 1);
    idle(10, 1);
    chk("t6_n", cnt2_log.size(), 5);
    begin
      int exp_c[5] = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++)
        chk($sformatf("t6_cnt%0d", i), (i < cnt2_log.size()) ? 32'(cnt2_log[i]) : 'x, exp_c[i]);
    end
    chk("t6_b_final", b_res_count, 1);
    chk("t6_a_count", a_res_count, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
